uart_tx_scheduler: RTL

// - Shares one UART transmit line between NREQ byte requesters; round-robin arbitration.
// - Serialises the granted byte as 8N1 (start, 8 data bits LSB first, STOP_BITS stop bits).
// - Bit timing comes from the x16 oversampling baud clock of the UART clock divider.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rr_arbiter.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler: frame constants, the
// transmitter state encoding and the round-robin index helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_OVS_DEFAULT = 16;

    // Arbitration indices are carried in 3 bits so up to 8 requesters fit.
    localparam int UART_ID_W   = 3;
    localparam int UART_MAXREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Index that is 'off' positions after 'base' in a ring of 'n' requesters.
    function automatic logic [UART_ID_W-1:0] rr_index(input int base, input int off, input int n);
        return UART_ID_W'((base + off) % n);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// -----------------------------------------------------------------------------
// uart_rr_arbiter
// Purely combinational round-robin pick. The search starts at the requester
// after last_grant and wraps, so the most recently served requester has the
// lowest priority.
//
// Ports
//   req        in   NREQ  request vector
//   last_grant in   3     index of the previously granted requester
//   winner     out  3     chosen requester (0 when valid is low)
//   valid      out  1     at least one request is pending
// -----------------------------------------------------------------------------
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]      req,
    input  logic [UART_ID_W-1:0] last_grant,
    output logic [UART_ID_W-1:0] winner,
    output logic                 valid
);

    // Widened copy so an index of UART_ID_W bits always selects in range.
    logic [UART_MAXREQ-1:0] req_ext;
    assign req_ext = UART_MAXREQ'(req);

    // Walk from the farthest candidate to the nearest; the nearest pending
    // request is assigned last and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise a path that skips the assignment infers a latch.
        winner = '0;
        valid  = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            if (req_ext[rr_index(int'(last_grant), off, NREQ)]) begin
                winner = rr_index(int'(last_grant), off, NREQ);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART TXD line between NREQ byte requesters with round-robin
// arbitration and sends each granted byte as an 8N1 frame (STOP_BITS stop
// bits). Bit timing is taken from the rising edges of the x16 baud clock.
//
// Ports
//   clk50     in   1        system clock
//   rst_n     in   1        asynchronous active-low reset
//   baud16    in   1        x16 oversampling baud clock, synchronous to clk50
//   req       in   NREQ     per-requester request level, held until ack
//   data      in   8*NREQ   byte i on data[8*i+7:8*i]
//   ack       out  NREQ     one-cycle pulse: byte of requester i latched
//   grant_id  out  3        requester owning the current/last frame
//   busy      out  1        frame in progress
//   txd       out  1        serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int OVS       = UART_OVS_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk50,
    input  logic                 rst_n,
    input  logic                 baud16,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    data,
    output logic [NREQ-1:0]      ack,
    output logic [UART_ID_W-1:0] grant_id,
    output logic                 busy,
    output logic                 txd
);

    localparam logic [4:0] BIT_LAST  = 5'(OVS - 1);
    localparam logic [4:0] STOP_LAST = 5'(OVS * STOP_BITS - 1);
    localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e           state_q, state_d;
    logic                  b_q;
    logic [4:0]            tick_cnt_q, tick_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [UART_ID_W-1:0]  last_grant_q, last_grant_d;
    logic [UART_ID_W-1:0]  grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;
    logic                  txd_q, txd_d;

    logic                  tick;
    logic [UART_ID_W-1:0]  winner;
    logic                  win_valid;
    logic [UART_MAXREQ-1:0] ack_ext;
    logic [7:0]            byte_ext [UART_MAXREQ];

    // One clk50 pulse per rising edge of baud16.
    assign tick = baud16 & ~b_q;

    // Byte lanes padded to the full index range so any winner selects cleanly.
    for (genvar i = 0; i < UART_MAXREQ; i++) begin : g_lane
        if (i < NREQ) begin : g_used
            assign byte_ext[i] = data[8*i +: 8];
        end else begin : g_unused
            assign byte_ext[i] = '0;
        end
    end

    uart_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        busy_d       = busy_q;
        ack_ext      = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Grant is not tick-aligned; a tick landing here is dropped,
                // which makes the start bit at most one tick short.
                if (win_valid) begin
                    ack_ext      = UART_MAXREQ'(1) << winner;
                    shift_d      = byte_ext[winner];
                    last_grant_d = winner;
                    grant_id_d   = winner;
                    busy_d       = 1'b1;
                    tick_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = '0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // txd is registered from the next state so the pin never glitches.
        unique case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            b_q          <= 1'b0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            last_grant_q <= UART_ID_W'(NREQ - 1);
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            txd_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            b_q          <= baud16;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            txd_q        <= txd_d;
        end
    end

    assign ack      = ack_ext[NREQ-1:0];
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign txd      = txd_q;

endmodule
